// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key matrix scanner.
//   scan_state_t    : scan FSM encodings
//   EVT_* positions : bit layout of the single-entry event register {key, pressed}
//   clog2_min1      : counter width helper (never returns less than 1)
package key_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_UPDATE,
        ST_NEXT
    } scan_state_t;

    // Event register layout: pressed flag in bit 0, key index above it.
    localparam int unsigned EVT_PRESSED_POS = 0;
    localparam int unsigned EVT_KEY_LSB     = 1;

    // Bits needed to hold 0..value-1, at least 1.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Row settle timer: loadable down-counter that stops at zero.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load iv_load_val (takes priority over counting)
//   i_run          : decrement while non-zero
//   o_done_c       : combinational, high while the count is zero
module scan_settle_timer #(
    parameter int unsigned p_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [p_WIDTH-1:0] iv_load_val,
    input  logic               i_run,
    output logic               o_done_c
);

    logic [p_WIDTH-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= iv_load_val;
        end else if (i_run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - p_WIDTH'(1);
        end
    end

    assign o_done_c = (cnt_q == '0);

endmodule

// File: rtl/key_matrix_scanner.sv
// Row-by-row key matrix scanner with per-key debounce counters sharing one
// update datapath. Debounced edges leave as single events on a valid/ready port.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : scan enable
//   ov_row         : active-low row drive (one-cold while scanning)
//   iv_col         : active-low column sense, pre-synchronised
//   o_valid/i_ready: event handshake; ov_key = row*p_COLS+col, o_pressed = polarity
//   ov_state       : debounced key bitmap
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int unsigned p_ROWS          = 4,
    parameter int unsigned p_COLS          = 4,
    parameter int unsigned p_CNT_WIDTH     = 3,
    parameter int unsigned p_SETTLE_CYCLES = 8,
    parameter int unsigned p_KEY_WIDTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    output logic [p_ROWS-1:0]        ov_row,
    input  logic [p_COLS-1:0]        iv_col,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [p_KEY_WIDTH-1:0]   ov_key,
    output logic                     o_pressed,
    output logic [p_ROWS*p_COLS-1:0] ov_state
);

    localparam int unsigned KEYS     = p_ROWS * p_COLS;
    localparam int unsigned ROW_W    = clog2_min1(p_ROWS);
    localparam int unsigned COL_W    = clog2_min1(p_COLS);
    localparam int unsigned SETTLE_W = clog2_min1(p_SETTLE_CYCLES);
    localparam int unsigned EVT_W    = p_KEY_WIDTH + 1;

    scan_state_t              state_q, state_nxt;
    logic [ROW_W-1:0]         row_q, row_nxt;
    logic [COL_W-1:0]         col_q, col_nxt;
    logic [p_COLS-1:0]        sample_q;
    logic [p_CNT_WIDTH-1:0]   cnt_q [KEYS];
    logic [p_ROWS-1:0]        row_drv_nxt;
    logic [EVT_W-1:0]         evt_q, evt_nxt;
    logic                     valid_nxt;
    logic                     tmr_load;
    logic                     tmr_done_c;
    logic                     commit;
    logic [p_KEY_WIDTH-1:0]   key_idx;
    logic                     sample_bit;
    logic                     stable_bit;
    logic [p_CNT_WIDTH-1:0]   cnt_cur;
    logic [p_CNT_WIDTH-1:0]   cnt_new;
    logic                     flip;

    // Settle timer: loaded on entry to DRIVE so DRIVE lasts p_SETTLE_CYCLES cycles.
    scan_settle_timer #(
        .p_WIDTH (SETTLE_W)
    ) u_settle (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (tmr_load),
        .iv_load_val (SETTLE_W'(p_SETTLE_CYCLES - 1)),
        .i_run       (state_q == ST_DRIVE),
        .o_done_c    (tmr_done_c)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_nxt;
            row_q   <= row_nxt;
            col_q   <= col_nxt;
        end
    end

    // Next-state logic; an UPDATE only commits when no event is left stranded.
    always_comb begin
        state_nxt = state_q;
        row_nxt   = row_q;
        col_nxt   = col_q;
        tmr_load  = 1'b0;
        commit    = 1'b0;
        if (!i_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_nxt = ST_DRIVE;
                    row_nxt   = '0;
                    tmr_load  = 1'b1;
                end
                ST_DRIVE: begin
                    if (tmr_done_c) begin
                        state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    state_nxt = ST_UPDATE;
                    col_nxt   = '0;
                end
                ST_UPDATE: begin
                    if (!o_valid || i_ready) begin
                        commit = 1'b1;
                        if (col_q == COL_W'(p_COLS - 1)) begin
                            state_nxt = ST_NEXT;
                        end else begin
                            col_nxt = col_q + COL_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    state_nxt = ST_DRIVE;
                    tmr_load  = 1'b1;
                    row_nxt   = (row_q == ROW_W'(p_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Shared debounce datapath for the key currently addressed by row/col.
    assign key_idx    = p_KEY_WIDTH'(row_q) * p_KEY_WIDTH'(p_COLS) + p_KEY_WIDTH'(col_q);
    assign sample_bit = sample_q[col_q];
    assign stable_bit = ov_state[key_idx];
    assign cnt_cur    = cnt_q[key_idx];

    always_comb begin
        cnt_new = '0;
        flip    = 1'b0;
        if (sample_bit != stable_bit) begin
            if (cnt_cur == {p_CNT_WIDTH{1'b1}}) begin
                flip = 1'b1;
            end else begin
                cnt_new = cnt_cur + p_CNT_WIDTH'(1);
            end
        end
    end

    // Single-entry event register; a same-cycle commit replaces an accepted event.
    always_comb begin
        valid_nxt = o_valid;
        evt_nxt   = evt_q;
        if (commit && flip) begin
            valid_nxt                               = 1'b1;
            evt_nxt[EVT_KEY_LSB +: p_KEY_WIDTH]     = key_idx;
            evt_nxt[EVT_PRESSED_POS]                = sample_bit;
        end else if (o_valid && i_ready) begin
            valid_nxt = 1'b0;
        end
    end

    // Row drive follows the next state so ov_row is registered yet aligned with it.
    always_comb begin
        row_drv_nxt = '1;
        if ((state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE) || (state_nxt == ST_UPDATE)) begin
            row_drv_nxt = ~({{(p_ROWS-1){1'b0}}, 1'b1} << row_nxt);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_row   <= '1;
            sample_q <= '0;
            ov_state <= '0;
            o_valid  <= 1'b0;
            evt_q    <= '0;
            for (int unsigned k = 0; k < KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            ov_row  <= row_drv_nxt;
            o_valid <= valid_nxt;
            evt_q   <= evt_nxt;
            if (state_q == ST_SAMPLE) begin
                sample_q <= ~iv_col;
            end
            if (commit) begin
                cnt_q[key_idx] <= cnt_new;
                if (flip) begin
                    ov_state[key_idx] <= sample_bit;
                end
            end
        end
    end

    assign ov_key    = evt_q[EVT_KEY_LSB +: p_KEY_WIDTH];
    assign o_pressed = evt_q[EVT_PRESSED_POS];

endmodule

// File: tb/tb_key_matrix_scanner.sv
module tb_key_matrix_scanner;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic [3:0]  ov_row;
    logic [3:0]  iv_col;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  ov_key;
    logic        o_pressed;
    logic [15:0] ov_state;

    logic [15:0] closed;

    typedef struct packed {
        logic [3:0] key;
        logic       pressed;
    } evt_t;

    evt_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   row1_scans = 0;
    int   valid_seen = 0;
    logic [3:0] mon_prev_row = 4'hf;

    key_matrix_scanner dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .ov_row    (ov_row),
        .iv_col    (iv_col),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .ov_key    (ov_key),
        .o_pressed (o_pressed),
        .ov_state  (ov_state)
    );

    always #5 i_clk = ~i_clk;

    // Switch matrix model: a closed switch pulls its column low when its row is driven.
    always_comb begin
        iv_col = 4'hf;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!ov_row[r] && closed[r*4+c]) iv_col[c] = 1'b0;
            end
        end
    end

    // Counts row-1 scans and cycles with an event pending.
    always @(negedge i_clk) begin
        if (ov_row == 4'b1101 && mon_prev_row != 4'b1101) row1_scans = row1_scans + 1;
        if (o_valid) valid_seen = valid_seen + 1;
        mon_prev_row = ov_row;
    end

    task automatic wait_row_start(input logic [3:0] pat, input int budget, output bit ok);
        logic [3:0] prev;
        prev = ov_row;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (ov_row == pat && prev != pat) begin
                ok = 1'b1;
                break;
            end
            prev = ov_row;
        end
    endtask

    // Waits for a handshake; returns at the posedge that accepts it.
    task automatic wait_evt(input int budget, output bit got, output evt_t ev, output int scans);
        got = 1'b0;
        ev = '0;
        scans = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_valid && i_ready) begin
                got = 1'b1;
                ev.key = ov_key;
                ev.pressed = o_pressed;
                scans = row1_scans;
                break;
            end
        end
        if (got) @(posedge i_clk);
    endtask

    task automatic test_reset();
        int bad;
        i_rst_n = 1'b0;
        i_en = 1'b0;
        i_ready = 1'b1;
        closed = '0;
        repeat (3) @(negedge i_clk);
        n_vec++;
        if (ov_row !== 4'b1111) begin n_err++; $display("FAIL reset_row: got %b expected 1111", ov_row); end
        n_vec++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_vec++;
        if (ov_state !== 16'h0) begin n_err++; $display("FAIL reset_state: got %h expected 0000", ov_state); end
        n_vec++;
        if (ov_key !== 4'h0 || o_pressed !== 1'b0) begin
            n_err++; $display("FAIL reset_event: got key %h pressed %b expected 0 0", ov_key, o_pressed);
        end
        i_rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (ov_row !== 4'b1111 || o_valid !== 1'b0 || ov_state !== 16'h0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_press_release();
        bit got;
        bit ok;
        evt_t ev;
        evt_t ex;
        int scans;
        int base;
        int v0;
        closed[5] = 1'b1;
        base = row1_scans;
        exp_q.push_back('{key: 4'd5, pressed: 1'b1});
        i_en = 1'b1;
        wait_evt(700, got, ev, scans);
        ex = exp_q.pop_front();
        n_vec++;
        if (!got || ev !== ex) begin
            n_err++; $display("FAIL press_evt: got %b key %h pressed %b expected key %h pressed %b", got, ev.key, ev.pressed, ex.key, ex.pressed);
        end
        n_vec++;
        if (scans - base != 8) begin n_err++; $display("FAIL press_latency: got scan %0d expected 8", scans - base); end
        n_vec++;
        if (ov_state !== 16'h0020) begin n_err++; $display("FAIL press_state: got %h expected 0020", ov_state); end
        v0 = valid_seen;
        repeat (120) @(negedge i_clk);
        n_vec++;
        if (valid_seen != v0) begin n_err++; $display("FAIL press_single: got %0d extra valid cycles expected 0", valid_seen - v0); end

        wait_row_start(4'b1110, 100, ok);
        closed[5] = 1'b0;
        base = row1_scans;
        exp_q.push_back('{key: 4'd5, pressed: 1'b0});
        wait_evt(700, got, ev, scans);
        ex = exp_q.pop_front();
        n_vec++;
        if (!ok || !got || ev !== ex) begin
            n_err++; $display("FAIL release_evt: got %b key %h pressed %b expected key %h pressed %b", got, ev.key, ev.pressed, ex.key, ex.pressed);
        end
        n_vec++;
        if (scans - base != 8) begin n_err++; $display("FAIL release_latency: got scan %0d expected 8", scans - base); end
        n_vec++;
        if (ov_state !== 16'h0) begin n_err++; $display("FAIL release_state: got %h expected 0000", ov_state); end
    endtask

    task automatic test_bounce();
        bit ok;
        int misses;
        int v0;
        misses = 0;
        v0 = valid_seen;
        for (int s = 0; s < 20; s++) begin
            wait_row_start(4'b1110, 100, ok);
            if (!ok) misses++;
            closed[10] = ~closed[10];
        end
        closed[10] = 1'b0;
        repeat (60) @(negedge i_clk);
        n_vec++;
        if (misses != 0 || valid_seen != v0) begin
            n_err++; $display("FAIL bounce_evt: got %0d valid cycles %0d timeouts expected 0 0", valid_seen - v0, misses);
        end
        n_vec++;
        if (ov_state !== 16'h0) begin n_err++; $display("FAIL bounce_state: got %h expected 0000", ov_state); end
    endtask

    task automatic test_backpressure();
        bit got;
        bit ok;
        evt_t ev;
        evt_t ex;
        int scans;
        int bad;
        i_ready = 1'b0;
        wait_row_start(4'b1110, 100, ok);
        closed[0] = 1'b1;
        closed[2] = 1'b1;
        exp_q.push_back('{key: 4'd0, pressed: 1'b1});
        exp_q.push_back('{key: 4'd2, pressed: 1'b1});
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge i_clk);
            if (o_valid) begin got = 1'b1; break; end
        end
        ev.key = ov_key;
        ev.pressed = o_pressed;
        n_vec++;
        if (!ok || !got || ev !== exp_q[0]) begin
            n_err++; $display("FAIL bp_first: got %b key %h pressed %b expected key 0 pressed 1", got, ev.key, ev.pressed);
        end
        bad = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (ov_row !== 4'b1110 || o_valid !== 1'b1 || ov_key !== ev.key || o_pressed !== ev.pressed) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL bp_stall: got %0d unstable cycles expected 0", bad); end
        n_vec++;
        if (ov_state !== 16'h0001) begin n_err++; $display("FAIL bp_state: got %h expected 0001", ov_state); end
        i_ready = 1'b1;
        @(negedge i_clk);
        ex = exp_q.pop_front();
        n_vec++;
        if (o_valid !== 1'b0 || ev !== ex) begin
            n_err++; $display("FAIL bp_accept: got valid %b key %h expected valid 0 key %h", o_valid, ev.key, ex.key);
        end
        @(negedge i_clk);
        ev.key = ov_key;
        ev.pressed = o_pressed;
        ex = exp_q.pop_front();
        n_vec++;
        if (o_valid !== 1'b1 || ev !== ex) begin
            n_err++; $display("FAIL bp_second: got valid %b key %h pressed %b expected valid 1 key %h pressed %b", o_valid, ev.key, ev.pressed, ex.key, ex.pressed);
        end
        n_vec++;
        if (ov_state !== 16'h0005) begin n_err++; $display("FAIL bp_state2: got %h expected 0005", ov_state); end
        @(posedge i_clk);
        closed[0] = 1'b0;
        closed[2] = 1'b0;
        exp_q.push_back('{key: 4'd0, pressed: 1'b0});
        exp_q.push_back('{key: 4'd2, pressed: 1'b0});
        for (int n = 0; n < 2; n++) begin
            wait_evt(700, got, ev, scans);
            ex = exp_q.pop_front();
            n_vec++;
            if (!got || ev !== ex) begin
                n_err++; $display("FAIL bp_release%0d: got %b key %h pressed %b expected key %h pressed %b", n, got, ev.key, ev.pressed, ex.key, ex.pressed);
            end
        end
        n_vec++;
        if (ov_state !== 16'h0) begin n_err++; $display("FAIL bp_state3: got %h expected 0000", ov_state); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int bad;
        wait_row_start(4'b1011, 200, ok);
        @(negedge i_clk);
        i_en = 1'b0;
        @(negedge i_clk);
        n_vec++;
        if (!ok || ov_row !== 4'b1111) begin n_err++; $display("FAIL en_drop: got %b expected 1111", ov_row); end
        bad = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (ov_row !== 4'b1111) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL en_idle: got %0d driven cycles expected 0", bad); end
        i_en = 1'b1;
        @(negedge i_clk);
        n_vec++;
        if (ov_row !== 4'b1110) begin n_err++; $display("FAIL en_restart: got %b expected 1110", ov_row); end
    endtask

    task automatic test_async_reset();
        bit got;
        i_ready = 1'b0;
        closed[15] = 1'b1;
        exp_q.push_back('{key: 4'd15, pressed: 1'b1});
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge i_clk);
            if (o_valid) begin got = 1'b1; break; end
        end
        n_vec++;
        if (!got || ov_key !== exp_q[0].key || o_pressed !== exp_q[0].pressed || ov_state !== 16'h8000) begin
            n_err++; $display("FAIL ar_pending: got %b key %h pressed %b state %h expected key f pressed 1 state 8000", got, ov_key, o_pressed, ov_state);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_vec++;
        if (o_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b expected 0", o_valid); end
        n_vec++;
        if (ov_state !== 16'h0) begin n_err++; $display("FAIL ar_state: got %h expected 0000", ov_state); end
        n_vec++;
        if (ov_row !== 4'b1111) begin n_err++; $display("FAIL ar_row: got %b expected 1111", ov_row); end
        @(negedge i_clk);
        closed = '0;
        i_ready = 1'b1;
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Scans a p_ROWS x p_COLS switch matrix one row at a time and debounces every key with a per-key tolerance counter. All keys share one counter-update datapath. Each debounced press or release is emitted as a single event on a valid/ready port, and a debounced key bitmap is exported. The block sits between the board keypad pins and the consuming logic, and replaces one debouncer instance per key.

Parameters:
p_ROWS, 4, number of matrix rows (driven outputs)
p_COLS, 4, number of matrix columns (sampled inputs)
p_CNT_WIDTH, 3, per-key tolerance counter width; a state change needs 2^p_CNT_WIDTH consecutive disagreeing scan samples
p_SETTLE_CYCLES, 8, clock cycles a row is driven before its columns are sampled (>=1)
p_KEY_WIDTH, 4, event key-index width; must satisfy 2^p_KEY_WIDTH >= p_ROWS*p_COLS

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  scan enable
ov_row  out  p_ROWS  row drive, active-low, one-cold while scanning
iv_col  in  p_COLS  column sense, active-low (0 = closed switch on the driven row); already synchronised externally
o_valid  out  1  event valid
i_ready  in  1  event accepted when o_valid && i_ready
ov_key  out  p_KEY_WIDTH  event key index = row*p_COLS + col
o_pressed  out  1  event polarity: 1 = press, 0 = release
ov_state  out  p_ROWS*p_COLS  debounced key bitmap, bit k = key k pressed

Behaviour:
- Reset (async assert, sync release): ov_row all ones, o_valid 0, ov_key 0, o_pressed 0, ov_state 0, all per-key counters 0, FSM in IDLE, row index 0.
- IDLE: ov_row all ones. Moves to DRIVE with row 0 on the first cycle i_en=1.
- DRIVE: ov_row = ~(1<<row). The settle timer runs p_SETTLE_CYCLES cycles, then the FSM goes to SAMPLE.
- SAMPLE (1 cycle): latches ~iv_col into the sample register. Goes to UPDATE with col=0.
- UPDATE (1 cycle per column, col 0..p_COLS-1): processes key k=row*p_COLS+col with sample s and stable bit b=ov_state[k].
  - s==b: cnt[k]<=0.
  - s!=b and cnt[k] not all-ones: cnt[k]<=cnt[k]+1.
  - s!=b and cnt[k] all-ones: ov_state[k]<=s, cnt[k]<=0, emit event {key=k, pressed=s}.
- Stall rule: UPDATE does not commit and col does not advance while o_valid && !i_ready. It commits in the same cycle the pending event is accepted.
- NEXT (1 cycle): ov_row all ones. row<=row+1, wrapping to 0 after p_ROWS-1. Goes to DRIVE.
- Timing: unstalled row period is p_SETTLE_CYCLES+p_COLS+2 cycles (14 at defaults); a full-matrix scan is 56 cycles at defaults.
- Event output is a single-entry register.
  - o_valid rises the cycle after the committing UPDATE.
  - o_valid drops after a handshake unless a new event commits in the same cycle.
  - ov_key and o_pressed are stable while o_valid && !i_ready.
- i_en deasserted in any state: the next cycle enters IDLE with rows released. Already-committed counter and state updates are kept. A pending event stays valid until accepted. On re-enable, scanning restarts at row 0.
- Reset mid-scan or mid-stall: immediate return to reset values; the pending event is discarded.
- Simultaneous presses in the same row emit in column order. Ghosting is not resolved by this block.

Decomposition:
- Package key_scan_pkg holds:
  - FSM state encodings: IDLE, DRIVE, SAMPLE, UPDATE, NEXT.
  - The event field layout.
  - A clog2 helper function used for the row, column and settle counter widths.
- Sub-module scan_settle_timer: loadable down-counter with a done pulse, used in DRIVE.

Test Plan:
- Reset and idle: hold i_rst_n=0, then release with i_en=0 -> ov_row=4'b1111, o_valid=0, ov_state=0 indefinitely.
- Clean press, defaults, i_ready=1: key 5 (row1, col1) held closed -> exactly one event {ov_key=5, o_pressed=1} on the 8th scan of row 1, ov_state[5]=1. Release -> one event {5, 0} after 8 more scans.
- Bounce rejection: key 10 alternates closed/open every scan for 20 scans -> no event, ov_state[10] stays 0.
- Backpressure: keys 0 and 2 pressed together, i_ready=0 -> o_valid=1 holding {0,1}, scan stalls, ov_row frozen at 4'b1110. Raise i_ready -> {0,1} accepted, then {2,1} two cycles later.
- Enable drop: clear i_en mid-DRIVE of row 2 -> ov_row=4'b1111 next cycle. Re-enable -> first driven row is 4'b1110.
- Async reset during a stalled event -> o_valid=0 and ov_state=0 immediately, without waiting for a clock edge.
